// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: register offsets, CTRL bit
// positions and bus mode encodings.
package multi_timer_pkg;

    localparam logic [31:0] CH_STRIDE = 32'h0000_0020;

    localparam logic [4:0] OFF_IRQ_STATUS = 5'h00;
    localparam logic [4:0] OFF_IRQ_ENABLE = 5'h04;

    localparam logic [4:0] OFF_CTRL      = 5'h00;
    localparam logic [4:0] OFF_PRESC_TH  = 5'h04;
    localparam logic [4:0] OFF_PERIOD    = 5'h08;
    localparam logic [4:0] OFF_COMPARE   = 5'h0C;
    localparam logic [4:0] OFF_PRESC_VAL = 5'h10;
    localparam logic [4:0] OFF_COUNT_VAL = 5'h14;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_CMP_EN  = 2;
    localparam int CTRL_CMP_POL = 3;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10,
        MODE_RSVD  = 2'b11
    } bus_mode_e;

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: prescaler, period counter, compare register and the
// registered compare/PWM output. period_evt pulses on the edge an event occurs.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           ctrl_wdata,
    input  logic [CNT_WIDTH-1:0] cnt_wdata,
    input  logic                 ctrl_we,
    input  logic                 presc_we,
    input  logic                 period_we,
    input  logic                 compare_we,
    output logic [3:0]           ctrl,
    output logic [CNT_WIDTH-1:0] presc_th,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] compare,
    output logic [CNT_WIDTH-1:0] presc_val,
    output logic [CNT_WIDTH-1:0] count_val,
    output logic                 cmp_out,
    output logic                 period_evt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [3:0]           ctrl_r;
    logic [CNT_WIDTH-1:0] presc_th_r;
    logic [CNT_WIDTH-1:0] period_r;
    logic [CNT_WIDTH-1:0] compare_r;
    logic [CNT_WIDTH-1:0] presc_val_r;
    logic [CNT_WIDTH-1:0] count_val_r;
    logic                 cmp_out_r;
    logic                 en_s;
    logic                 tick_s;
    logic                 count_hit_s;
    logic                 cmp_next_s;

    // A CTRL write restarts the channel, so it suppresses counting that cycle.
    assign en_s        = ctrl_r[CTRL_EN];
    assign tick_s      = en_s && !ctrl_we && (presc_val_r == presc_th_r);
    assign count_hit_s = (count_val_r == period_r);
    assign period_evt  = tick_s && count_hit_s;

    // Compare level derived from the pre-edge count.
    always_comb begin
        cmp_next_s = 1'b0;
        if (en_s && ctrl_r[CTRL_CMP_EN]) begin
            cmp_next_s = (count_val_r < compare_r) ^ ctrl_r[CTRL_CMP_POL];
        end else begin
            cmp_next_s = 1'b0;
        end
    end

    // Channel registers, counters and compare output flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_r      <= 4'h0;
            presc_th_r  <= '0;
            period_r    <= '0;
            compare_r   <= '0;
            presc_val_r <= '0;
            count_val_r <= '0;
            cmp_out_r   <= 1'b0;
        end else begin
            cmp_out_r <= cmp_next_s;
            if (ctrl_we) begin
                ctrl_r      <= ctrl_wdata;
                presc_val_r <= '0;
                count_val_r <= '0;
            end else if (en_s) begin
                if (tick_s) begin
                    presc_val_r <= '0;
                    if (count_hit_s) begin
                        count_val_r <= '0;
                        if (ctrl_r[CTRL_ONESHOT]) begin
                            ctrl_r[CTRL_EN] <= 1'b0;
                        end
                    end else begin
                        count_val_r <= count_val_r + CNT_ONE;
                    end
                end else begin
                    presc_val_r <= presc_val_r + CNT_ONE;
                end
            end
            if (presc_we) begin
                presc_th_r <= cnt_wdata;
            end
            if (period_we) begin
                period_r <= cnt_wdata;
            end
            if (compare_we) begin
                compare_r <= cnt_wdata;
            end
        end
    end

    assign ctrl      = ctrl_r;
    assign presc_th  = presc_th_r;
    assign period    = period_r;
    assign compare   = compare_r;
    assign presc_val = presc_val_r;
    assign count_val = count_val_r;
    assign cmp_out   = cmp_out_r;

endmodule

// File: rtl/multi_timer.sv
// N-channel timer/PWM peripheral: bus decode, read mux, sticky IRQ status with
// per-channel enables and the combined registered interrupt line.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h40C0,
    parameter int          NUM_CH    = 4,
    parameter int          CNT_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       data_bus_write,
    output logic [31:0]       data_bus_read,
    input  logic [31:0]       data_bus_addr,
    input  logic [1:0]        data_bus_mode,
    input  logic              data_bus_select,
    output logic              timer_irq,
    output logic [NUM_CH-1:0] cmp_out
);

    logic [31:0]             off_s;
    logic                    in_range_s;
    logic [26:0]             blk_s;
    logic [4:0]              reg_off_s;
    logic                    wr_en_s;
    logic                    glob_sel_s;
    logic                    status_we_s;
    logic                    enable_we_s;
    logic [NUM_CH-1:0]       ch_sel_s;
    logic [NUM_CH-1:0]       evt_s;
    logic [NUM_CH-1:0]       clr_mask_s;
    logic [NUM_CH-1:0][31:0] ch_rd_s;
    logic [31:0]             glob_rd_s;
    logic [31:0]             rd_mux_s;
    logic [NUM_CH-1:0]       irq_status_r;
    logic [NUM_CH-1:0]       irq_enable_r;
    logic                    timer_irq_r;

    // Block 0 is the global register block, block n+1 is channel n.
    assign off_s       = data_bus_addr - BASE_ADDR;
    assign in_range_s  = (data_bus_addr >= BASE_ADDR);
    assign blk_s       = off_s[31:5];
    assign reg_off_s   = off_s[4:0];
    assign wr_en_s     = data_bus_select && (data_bus_mode == MODE_WRITE);
    assign glob_sel_s  = in_range_s && (blk_s == 27'd0);
    assign status_we_s = wr_en_s && glob_sel_s && (reg_off_s == OFF_IRQ_STATUS);
    assign enable_we_s = wr_en_s && glob_sel_s && (reg_off_s == OFF_IRQ_ENABLE);
    assign clr_mask_s  = status_we_s ? data_bus_write[NUM_CH-1:0] : {NUM_CH{1'b0}};

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [3:0]           ctrl_s;
        logic [CNT_WIDTH-1:0] presc_th_s;
        logic [CNT_WIDTH-1:0] period_s;
        logic [CNT_WIDTH-1:0] compare_s;
        logic [CNT_WIDTH-1:0] presc_val_s;
        logic [CNT_WIDTH-1:0] count_val_s;
        logic [31:0]          rd_s;

        assign ch_sel_s[n] = in_range_s && (blk_s == 27'(n + 1));

        timer_channel #(.CNT_WIDTH(CNT_WIDTH)) u_channel (
            .clk        (clk),
            .reset      (reset),
            .ctrl_wdata (data_bus_write[3:0]),
            .cnt_wdata  (data_bus_write[CNT_WIDTH-1:0]),
            .ctrl_we    (wr_en_s && ch_sel_s[n] && (reg_off_s == OFF_CTRL)),
            .presc_we   (wr_en_s && ch_sel_s[n] && (reg_off_s == OFF_PRESC_TH)),
            .period_we  (wr_en_s && ch_sel_s[n] && (reg_off_s == OFF_PERIOD)),
            .compare_we (wr_en_s && ch_sel_s[n] && (reg_off_s == OFF_COMPARE)),
            .ctrl       (ctrl_s),
            .presc_th   (presc_th_s),
            .period     (period_s),
            .compare    (compare_s),
            .presc_val  (presc_val_s),
            .count_val  (count_val_s),
            .cmp_out    (cmp_out[n]),
            .period_evt (evt_s[n])
        );

        // Per-channel register read selection.
        always_comb begin
            rd_s = 32'h0;
            case (reg_off_s)
                OFF_CTRL:      rd_s = {28'h0, ctrl_s};
                OFF_PRESC_TH:  rd_s = 32'(presc_th_s);
                OFF_PERIOD:    rd_s = 32'(period_s);
                OFF_COMPARE:   rd_s = 32'(compare_s);
                OFF_PRESC_VAL: rd_s = 32'(presc_val_s);
                OFF_COUNT_VAL: rd_s = 32'(count_val_s);
                default:       rd_s = 32'h0;
            endcase
        end

        assign ch_rd_s[n] = ch_sel_s[n] ? rd_s : 32'h0;
    end

    // Global register read selection.
    always_comb begin
        glob_rd_s = 32'h0;
        case (reg_off_s)
            OFF_IRQ_STATUS: glob_rd_s = 32'(irq_status_r);
            OFF_IRQ_ENABLE: glob_rd_s = 32'(irq_enable_r);
            default:        glob_rd_s = 32'h0;
        endcase
    end

    // At most one block is selected, so OR-ing the gated sources is the mux.
    always_comb begin
        rd_mux_s = glob_sel_s ? glob_rd_s : 32'h0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_mux_s = rd_mux_s | ch_rd_s[i];
        end
    end

    assign data_bus_read = rd_mux_s;

    // Sticky status (a same-edge event beats a W1C), enables and the IRQ flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_status_r <= {NUM_CH{1'b0}};
            irq_enable_r <= {NUM_CH{1'b0}};
            timer_irq_r  <= 1'b0;
        end else begin
            irq_status_r <= (irq_status_r & ~clr_mask_s) | evt_s;
            if (enable_we_s) begin
                irq_enable_r <= data_bus_write[NUM_CH-1:0];
            end
            timer_irq_r <= |(irq_status_r & irq_enable_r);
        end
    end

    assign timer_irq = timer_irq_r;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: a register-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_multi_timer;

    localparam logic [31:0] BASE  = 32'h40C0;
    localparam int          NCH   = 4;
    localparam int          CW    = 8;
    localparam int unsigned MASK  = (32'd1 << CW) - 32'd1;
    localparam int unsigned NMASK = (32'd1 << NCH) - 32'd1;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic [31:0]     wdata = 32'h0;
    logic [31:0]     addr  = 32'h0;
    logic [1:0]      mode  = 2'b00;
    logic            sel   = 1'b0;
    logic [31:0]     rdata;
    logic            irq;
    logic [NCH-1:0]  cmp;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    multi_timer #(.BASE_ADDR(BASE), .NUM_CH(NCH), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_bus_write  (wdata),
        .data_bus_read   (rdata),
        .data_bus_addr   (addr),
        .data_bus_mode   (mode),
        .data_bus_select (sel),
        .timer_irq       (irq),
        .cmp_out         (cmp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int unsigned m_ctrl[NCH], m_pth[NCH], m_per[NCH], m_cmpv[NCH], m_pv[NCH], m_cv[NCH];
    bit          m_out[NCH];
    int unsigned m_status = 0, m_enable = 0;
    bit          m_irq = 1'b0;

    function automatic logic [31:0] reg_addr(input int n, input int unsigned o);
        return BASE + 32'(32 * (n + 1)) + o;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == BASE) return m_status;
        if (a == BASE + 32'd4) return m_enable;
        for (int n = 0; n < NCH; n++) begin
            if (a == reg_addr(n, 32'h00)) return m_ctrl[n];
            if (a == reg_addr(n, 32'h04)) return m_pth[n];
            if (a == reg_addr(n, 32'h08)) return m_per[n];
            if (a == reg_addr(n, 32'h0C)) return m_cmpv[n];
            if (a == reg_addr(n, 32'h10)) return m_pv[n];
            if (a == reg_addr(n, 32'h14)) return m_cv[n];
        end
        return 32'h0;
    endfunction

    always @(posedge clk) begin : model
        int unsigned ev;
        bit wr, en;
        wr = sel && (mode == 2'b10);
        if (!reset) begin
            for (int n = 0; n < NCH; n++) begin
                m_ctrl[n] = 0; m_pth[n] = 0; m_per[n] = 0; m_cmpv[n] = 0;
                m_pv[n] = 0; m_cv[n] = 0; m_out[n] = 1'b0;
            end
            m_status = 0; m_enable = 0; m_irq = 1'b0;
        end else begin
            ev = 0;
            m_irq = ((m_status & m_enable) != 0);
            for (int n = 0; n < NCH; n++) begin
                en = (m_ctrl[n] & 1) != 0;
                if (en && (m_ctrl[n] & 4) != 0)
                    m_out[n] = (m_cv[n] < m_cmpv[n]) ^ ((m_ctrl[n] & 8) != 0);
                else
                    m_out[n] = 1'b0;
                if (wr && addr == reg_addr(n, 32'h00)) begin
                    m_ctrl[n] = wdata & 32'hF;
                    m_pv[n] = 0;
                    m_cv[n] = 0;
                end else if (en) begin
                    if (m_pv[n] == m_pth[n]) begin
                        m_pv[n] = 0;
                        if (m_cv[n] == m_per[n]) begin
                            m_cv[n] = 0;
                            ev |= (32'd1 << n);
                            if ((m_ctrl[n] & 2) != 0) m_ctrl[n] &= ~32'd1;
                        end else begin
                            m_cv[n] = (m_cv[n] + 1) & MASK;
                        end
                    end else begin
                        m_pv[n] = (m_pv[n] + 1) & MASK;
                    end
                end
                if (wr && addr == reg_addr(n, 32'h04)) m_pth[n]  = wdata & MASK;
                if (wr && addr == reg_addr(n, 32'h08)) m_per[n]  = wdata & MASK;
                if (wr && addr == reg_addr(n, 32'h0C)) m_cmpv[n] = wdata & MASK;
            end
            if (wr && addr == BASE) m_status &= ~wdata;
            m_status = (m_status | ev) & NMASK;
            if (wr && addr == BASE + 32'd4) m_enable = wdata & NMASK;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [NCH-1:0] exp_cmp;
        if (chk_en) begin
            for (int n = 0; n < NCH; n++) exp_cmp[n] = m_out[n];
            check("cmp_out", 32'(cmp), 32'(exp_cmp));
            check("timer_irq", 32'(irq), 32'(m_irq));
            check("read_data", rdata, model_read(addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; mode = 2'b10; sel = 1'b1;
        tick(1);
        mode = 2'b00; sel = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; mode = 2'b01; sel = 1'b1;
        #2;
        d = rdata;
        mode = 2'b00; sel = 1'b0;
    endtask

    // Cycles from start_cyc until IRQ_STATUS bit b reads 1, or -1 after 60 cycles.
    task automatic wait_status(input int b, input int start_cyc, output int dt);
        logic [31:0] d;
        dt = -1;
        for (int k = 0; k < 60; k++) begin
            bus_read(BASE, d);
            if (d[b]) begin
                dt = cyc - start_cyc;
                break;
            end
            tick(1);
        end
    endtask

    initial begin : stim
        logic [31:0] d;
        int wr_cyc, dt, hi;
        logic [31:0] offs [8];
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h02};

        reset = 1'b0;
        tick(3);
        chk_en = 1'b1;
        reset = 1'b1;
        tick(1);

        // Periodic: (2+1)*(3+1) = 12 clocks per event.
        bus_write(BASE + 32'd4, 32'h1);
        bus_write(reg_addr(0, 32'h04), 32'd2);
        bus_write(reg_addr(0, 32'h08), 32'd3);
        bus_write(reg_addr(0, 32'h00), 32'h1);
        wr_cyc = cyc;
        wait_status(0, wr_cyc, dt);
        check("periodic_first_event", 32'(dt), 32'd12);
        check("irq_before_latency", 32'(irq), 32'd0);
        tick(1);
        check("irq_after_latency", 32'(irq), 32'd1);
        bus_write(BASE, 32'h1);
        bus_read(BASE, d);
        check("w1c_clears", d, 32'h0);
        wait_status(0, wr_cyc, dt);
        check("periodic_second_event", 32'(dt), 32'd24);

        // One-shot on channel 1.
        bus_write(reg_addr(0, 32'h00), 32'h0);
        bus_write(BASE, 32'hF);
        bus_write(BASE + 32'd4, 32'h2);
        bus_write(reg_addr(1, 32'h04), 32'd0);
        bus_write(reg_addr(1, 32'h08), 32'd4);
        bus_write(reg_addr(1, 32'h00), 32'h3);
        wr_cyc = cyc;
        wait_status(1, wr_cyc, dt);
        check("oneshot_event", 32'(dt), 32'd5);
        bus_read(reg_addr(1, 32'h00), d);
        check("oneshot_ctrl", d, 32'h2);
        tick(20);
        bus_read(reg_addr(1, 32'h14), d);
        check("oneshot_count_hold", d, 32'h0);

        // PWM on channel 2.
        bus_write(reg_addr(2, 32'h04), 32'd0);
        bus_write(reg_addr(2, 32'h08), 32'd9);
        bus_write(reg_addr(2, 32'h0C), 32'd3);
        bus_write(reg_addr(2, 32'h00), 32'h5);
        tick(2);
        hi = 0;
        for (int i = 0; i < 100; i++) begin hi += int'(cmp[2]); tick(1); end
        check("pwm_high_count", 32'(hi), 32'd30);
        bus_write(reg_addr(2, 32'h00), 32'hD);
        tick(2);
        hi = 0;
        for (int i = 0; i < 100; i++) begin hi += int'(cmp[2]); tick(1); end
        check("pwm_inverted_count", 32'(hi), 32'd70);
        bus_write(reg_addr(2, 32'h00), 32'h0);

        // Collision: events every 4 clocks; W1C lands on an event edge.
        bus_write(BASE, 32'hF);
        bus_write(reg_addr(0, 32'h04), 32'd0);
        bus_write(reg_addr(0, 32'h08), 32'd3);
        bus_write(reg_addr(0, 32'h00), 32'h1);
        tick(4);
        bus_write(BASE, 32'h1);
        bus_read(BASE, d);
        check("collision_pre_clear", d & 32'h1, 32'h0);
        tick(2);
        bus_write(BASE, 32'h1);
        bus_read(BASE, d);
        check("collision_set_wins", d & 32'h1, 32'h1);

        // Decode of a channel beyond NCH and an unmapped global offset.
        bus_write(reg_addr(NCH, 32'h04), 32'h55);
        bus_read(reg_addr(NCH, 32'h04), d);
        check("decode_no_channel", d, 32'h0);
        bus_read(BASE + 32'h8, d);
        check("decode_unmapped_global", d, 32'h0);
        bus_write(reg_addr(2, 32'h14), 32'h77);
        bus_read(reg_addr(2, 32'h14), d);
        check("decode_ro_count", d, 32'h0);

        // Reset during active counting with a live PWM output.
        bus_write(BASE + 32'd4, 32'hF);
        bus_write(reg_addr(0, 32'h0C), 32'd2);
        bus_write(reg_addr(0, 32'h00), 32'h5);
        tick(3);
        reset = 1'b0;
        tick(2);
        check("reset_cmp_out", 32'(cmp), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        bus_read(BASE, d);
        check("reset_status", d, 32'h0);
        bus_read(reg_addr(0, 32'h00), d);
        check("reset_ctrl", d, 32'h0);
        bus_read(reg_addr(0, 32'h10), d);
        check("reset_presc_val", d, 32'h0);
        reset = 1'b1;
        tick(1);

        // Random traffic checked against the model every cycle.
        for (int it = 0; it < 4000; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 1) begin
                reset = 1'b0;
                tick(int'($urandom_range(1, 2)));
                reset = 1'b1;
            end else begin
                addr = BASE + 32'($urandom_range(0, NCH + 1) * 32) + offs[$urandom_range(0, 7)];
                if ($urandom_range(0, 49) == 0) addr = BASE - 32'd4;
                wdata = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
                if (r < 35) begin
                    mode = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'b10;
                    sel  = ($urandom_range(0, 9) != 0);
                end else begin
                    mode = 2'b01;
                    sel  = 1'b1;
                end
                tick(1);
                mode = 2'b00;
                sel  = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
